gshare_btb_predictor: RTL

Parametrised branch predictor for the pipelined RV32I core. It supplies the IF stage with a next-PC guess each cycle and trains on resolved control-flow instructions reported from EX. It combines three structures, all sized by parameters:
- a direct-mapped branch target buffer (BTB);
- a gshare pattern history table (PHT) of saturating counters;
- a speculative global history register (GHR), with recovery on mispredict.

---
 rtl/gshare_btb_predictor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gshare_btb_predictor.sv
// Next-PC predictor for the RV32I front end: a direct-mapped BTB, a gshare table of
// saturating counters and a speculative global history that is repaired on mispredict.
module gshare_btb_predictor #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 5,
    parameter int GHR_BITS   = 5,
    parameter int CTR_BITS   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     if_pc,
    input  logic                if_fire,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_next_pc,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_is_cond,
    input  logic                upd_is_jump,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic                upd_pred_taken,
    input  logic [XLEN-1:0]     upd_pred_next_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    output logic                mispredict
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = XLEN - INDEX_BITS - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

    logic                btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
    logic [XLEN-1:0]     btb_target [ENTRIES];
    logic                btb_cond   [ENTRIES];
    logic [CTR_BITS-1:0] pht        [ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_next;

    logic [INDEX_BITS-1:0] if_idx, if_pidx, upd_idx, upd_pidx;
    logic [TAG_BITS-1:0]   if_tag, upd_tag;
    logic                  hit;
    logic                  is_ctrl;
    logic [XLEN-1:0]       actual_next;
    logic [CTR_BITS-1:0]   ctr_cur, ctr_next;
    logic [GHR_BITS-1:0]   spec_ghr, rec_ghr;

    // The carried prediction flag is redundant with the carried next PC.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    assign if_idx   = if_pc[INDEX_BITS+1:2];
    assign if_tag   = if_pc[XLEN-1:INDEX_BITS+2];
    assign upd_idx  = upd_pc[INDEX_BITS+1:2];
    assign upd_tag  = upd_pc[XLEN-1:INDEX_BITS+2];
    assign if_pidx  = if_idx ^ INDEX_BITS'(ghr);
    assign upd_pidx = upd_idx ^ INDEX_BITS'(upd_ghr);

    assign hit          = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    assign pred_taken   = hit && (!btb_cond[if_idx] || pht[if_pidx][CTR_BITS-1]);
    assign pred_next_pc = pred_taken ? btb_target[if_idx] : if_pc + XLEN'(4);
    assign pred_ghr     = ghr;

    assign is_ctrl     = upd_is_cond || upd_is_jump;
    assign actual_next = upd_taken ? upd_target : upd_pc + XLEN'(4);
    assign mispredict  = upd_valid && is_ctrl && (upd_pred_next_pc != actual_next);

    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            assign spec_ghr = pred_taken;
            assign rec_ghr  = upd_taken;
        end else begin : g_ghr_shift
            assign spec_ghr = {ghr[GHR_BITS-2:0], pred_taken};
            assign rec_ghr  = {upd_ghr[GHR_BITS-2:0], upd_taken};
        end
    endgenerate

    // Repair from the resolving instruction outranks the speculative shift.
    always_comb begin
        ghr_next = ghr;
        if (mispredict && upd_is_cond)
            ghr_next = rec_ghr;
        else if (mispredict && upd_is_jump)
            ghr_next = upd_ghr;
        else if (if_fire && hit && btb_cond[if_idx])
            ghr_next = spec_ghr;
    end

    always_comb begin
        ctr_cur  = pht[upd_pidx];
        ctr_next = ctr_cur;
        if (upd_taken && ctr_cur != CTR_MAX)
            ctr_next = ctr_cur + CTR_BITS'(1);
        else if (!upd_taken && ctr_cur != '0)
            ctr_next = ctr_cur - CTR_BITS'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_cond[i]   <= 1'b0;
                pht[i]        <= CTR_INIT;
            end
            ghr <= '0;
        end else begin
            if (upd_valid && upd_taken && is_ctrl) begin
                btb_valid[upd_idx]  <= 1'b1;
                btb_tag[upd_idx]    <= upd_tag;
                btb_target[upd_idx] <= upd_target;
                btb_cond[upd_idx]   <= upd_is_cond;
            end
            if (upd_valid && upd_is_cond)
                pht[upd_pidx] <= ctr_next;
            ghr <= ghr_next;
        end
    end

endmodule
